// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with CTRL/PRESET/COUNT registers and a maskable expiry interrupt.
// Define TC_IRQ_EN to build the pending flag, the IM bit and the irq output; otherwise irq is tied low.
module timer_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:2]       addr,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             irq
);

  // state | meaning
  // IDLE  | waiting for EN
  // LOAD  | COUNT <= PRESET
  // CNT   | decrementing, expiry checked before decrement
  // INT   | expired: one-shot stops, auto-reload reloads
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t state, stateNext;

  logic             ctrlEn;
  logic [1:0]       ctrlMode;
  logic             ctrlIm;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] count;

  logic oneShot;
  logic ctrlWr;
  logic ctrlByte0Wr;
  logic presetWr;
  logic loadCount;
  logic decCount;
  logic expire;
  logic clrEn;

  assign oneShot     = (ctrlMode != 2'b01);
  assign ctrlWr      = we && (addr == 2'd0) && (be != 4'b0000);
  assign ctrlByte0Wr = we && (addr == 2'd0) && be[0];
  assign presetWr    = we && (addr == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (ctrlEn) stateNext = LOAD;
      LOAD: stateNext = CNT;
      CNT: begin
        if (!ctrlEn)            stateNext = IDLE;
        else if (count == '0)   stateNext = INT;
      end
      INT:     stateNext = oneShot ? IDLE : LOAD;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    loadCount = (state == LOAD);
    decCount  = (state == CNT) && ctrlEn && (count != '0);
    expire    = (state == CNT) && ctrlEn && (count == '0);
    clrEn     = (state == INT) && oneShot;
  end

  // A CPU write to CTRL lands after the one-shot EN clear, so the CPU value wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrlEn   <= 1'b0;
      ctrlMode <= 2'b00;
    end else begin
      if (clrEn) ctrlEn <= 1'b0;
      if (ctrlByte0Wr) begin
        ctrlEn   <= din[0];
        ctrlMode <= din[2:1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preset <= '0;
    end else if (presetWr) begin
      for (int i = 0; i < WIDTH/8; i++)
        if (be[i]) preset[8*i +: 8] <= din[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         count <= '0;
    else if (loadCount) count <= preset;
    else if (decCount)  count <= count - 1'b1;
  end

`ifdef TC_IRQ_EN
  logic irqPend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ctrlIm <= 1'b0;
    else if (ctrlByte0Wr)       ctrlIm <= din[3];
  end

  // Setting the pending flag takes priority over a clearing CTRL write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      irqPend <= 1'b0;
    else if (expire)
      irqPend <= 1'b1;
    else if (((state == INT) && !oneShot) || (ctrlWr && oneShot))
      irqPend <= 1'b0;
  end

  assign irq = irqPend & ctrlIm;
`else
  logic unusedIrq;
  assign unusedIrq = expire | ctrlWr;
  assign ctrlIm    = 1'b0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    dout = '0;
    case (addr)
      2'd0:    dout = {{(WIDTH-4){1'b0}}, ctrlIm, ctrlMode, ctrlEn};
      2'd1:    dout = preset;
      2'd2:    dout = count;
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboarded bench for timer_counter: a driver steps a reference model and queues expected outputs,
// a monitor compares dout/irq after every edge.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] dout;
    logic        irq;
    string       tag;
  } exp_t;

  exp_t sb[$];
  string phaseTag = "reset";

  timer_counter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .be(be),
    .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_EXPIRED} mphase_t;
  mphase_t     mPhase = M_IDLE;
  bit          mEn = 0;
  bit [1:0]    mMode = 0;
  bit          mIm = 0;
  bit          mPend = 0;
  bit [31:0]   mPreset = 0;
  bit [31:0]   mCount = 0;

  function automatic bit [31:0] readModel(input bit [1:0] a);
    case (a)
      2'd0: begin
`ifdef TC_IRQ_EN
        return {28'h0, mIm, mMode, mEn};
`else
        return {28'h0, 1'b0, mMode, mEn};
`endif
      end
      2'd1:    return mPreset;
      2'd2:    return mCount;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit irqModel();
`ifdef TC_IRQ_EN
    return mPend & mIm;
`else
    return 1'b0;
`endif
  endfunction

  task automatic modelStep();
    bit oneShot;
    bit expireNow;
    bit reloadNow;
    bit stopNow;
    mphase_t nextPhase;
    bit [31:0] nextCount;
    if (!rst_n) begin
      mPhase = M_IDLE; mEn = 0; mMode = 0; mIm = 0; mPend = 0; mPreset = 0; mCount = 0;
      return;
    end
    oneShot   = (mMode != 2'd1);
    expireNow = 0; reloadNow = 0; stopNow = 0;
    nextPhase = mPhase;
    nextCount = mCount;
    if (mPhase == M_IDLE && mEn) nextPhase = M_LOAD;
    else if (mPhase == M_LOAD) begin
      nextCount = mPreset;
      nextPhase = M_RUN;
    end else if (mPhase == M_RUN) begin
      if (!mEn) nextPhase = M_IDLE;
      else if (mCount == 0) begin nextPhase = M_EXPIRED; expireNow = 1; end
      else nextCount = mCount - 1;
    end else if (mPhase == M_EXPIRED) begin
      if (oneShot) begin stopNow = 1; nextPhase = M_IDLE; end
      else begin reloadNow = 1; nextPhase = M_LOAD; end
    end
    if (expireNow) mPend = 1;
    else if (reloadNow || (we && addr == 0 && be != 0 && oneShot)) mPend = 0;
    if (stopNow) mEn = 0;
    if (we && addr == 0 && be[0]) begin
      mEn = din[0];
      mMode = din[2:1];
      mIm = din[3];
    end
    if (we && addr == 1)
      for (int i = 0; i < 4; i++)
        if (be[i]) mPreset[8*i +: 8] = din[8*i +: 8];
    mCount = nextCount;
    mPhase = nextPhase;
  endtask

  task automatic cycle(input bit w, input bit [1:0] a, input bit [3:0] b,
                       input bit [31:0] d, input bit r = 1'b1);
    exp_t e;
    @(negedge clk);
    rst_n = r; we = w; addr = a; be = b; din = d;
    @(posedge clk);
    modelStep();
    e.dout = readModel(addr);
    e.irq  = irqModel();
    e.tag  = phaseTag;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'($urandom_range(0, 3)), 4'h0, 32'h0);
  endtask

  task automatic idleAddr(input int n, input bit [1:0] a);
    for (int i = 0; i < n; i++) cycle(1'b0, a, 4'h0, 32'h0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dout !== e.dout) begin
        fails++;
        $display("FAIL %s dout addr=%0d: got %h expected %h at %0t", e.tag, addr, dout, e.dout, $time);
      end
      checks++;
      if (irq !== e.irq) begin
        fails++;
        $display("FAIL %s irq: got %b expected %b at %0t", e.tag, irq, e.irq, $time);
      end
    end
  end

  initial begin
    phaseTag = "reset";
    for (int a = 0; a < 4; a++) cycle(1'b0, 2'(a), 4'h0, 32'h0, 1'b0);

    phaseTag = "oneshot";
    cycle(1'b1, 2'd1, 4'hF, 32'd5);
    cycle(1'b1, 2'd0, 4'hF, 32'h9);
    idleAddr(8, 2'd2);
    idleAddr(3, 2'd0);
    cycle(1'b1, 2'd0, 4'h1, 32'h8);
    idle(3);

    phaseTag = "autoreload";
    cycle(1'b1, 2'd0, 4'h1, 32'hB);
    idleAddr(26, 2'd2);
    cycle(1'b1, 2'd0, 4'h1, 32'h0);
    idle(3);

    phaseTag = "byteen";
    cycle(1'b1, 2'd1, 4'hF, 32'h0);
    cycle(1'b1, 2'd1, 4'b0101, 32'hAABBCCDD);
    idleAddr(1, 2'd1);
    cycle(1'b1, 2'd2, 4'hF, 32'h12345678);
    idleAddr(1, 2'd2);
    cycle(1'b1, 2'd3, 4'hF, 32'hFFFFFFFF);
    idleAddr(1, 2'd3);
    cycle(1'b1, 2'd0, 4'h0, 32'h9);
    idleAddr(1, 2'd0);

    phaseTag = "disable";
    cycle(1'b1, 2'd1, 4'hF, 32'd10);
    cycle(1'b1, 2'd0, 4'h1, 32'h1);
    idleAddr(8, 2'd2);
    cycle(1'b1, 2'd0, 4'h1, 32'h0);
    idleAddr(4, 2'd2);

    phaseTag = "collision";
    cycle(1'b1, 2'd1, 4'hF, 32'd3);
    cycle(1'b1, 2'd0, 4'h1, 32'h9);
    idleAddr(6, 2'd2);
    cycle(1'b1, 2'd0, 4'h1, 32'h9);
    idleAddr(3, 2'd0);
    idleAddr(9, 2'd2);

    phaseTag = "mask";
    cycle(1'b1, 2'd0, 4'h1, 32'h0);
    cycle(1'b1, 2'd1, 4'hF, 32'd2);
    cycle(1'b1, 2'd0, 4'h1, 32'h1);
    idle(8);
    cycle(1'b1, 2'd0, 4'h1, 32'h8);
    idle(3);

    phaseTag = "midreset";
    cycle(1'b1, 2'd1, 4'hF, 32'd20);
    cycle(1'b1, 2'd0, 4'h1, 32'hB);
    idleAddr(5, 2'd2);
    for (int a = 0; a < 4; a++) cycle(1'b0, 2'(a), 4'h0, 32'h0, 1'b0);
    idleAddr(5, 2'd2);
    idleAddr(2, 2'd0);

    phaseTag = "random";
    for (int i = 0; i < 400; i++) begin
      bit w;
      bit [1:0] a;
      bit [31:0] d;
      w = ($urandom_range(0, 7) == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d = {24'h0, 8'($urandom_range(0, 9))};
      else if (a == 2'd0 && w) d = {28'h0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0)};
      cycle(w, a, 4'($urandom_range(0, 15)), d);
    end

    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
